// File: rtl/draw_pkg.sv
// ---------------------------------------------------------------------------
// draw_pkg
// Shared types and defaults for the drawing pipeline that sits between the
// game logic and the framebuffer write port.
//   xcoord_t        : screen x coordinate (10 bits)
//   ycoord_t        : screen y coordinate (9 bits)
//   painter_state_t : square_painter FSM states
//   DEFAULT_*       : default screen geometry and square size
// ---------------------------------------------------------------------------
package draw_pkg;

    typedef logic [9:0] xcoord_t;
    typedef logic [8:0] ycoord_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SYNC,
        WAIT,
        PAINT,
        DONE
    } painter_state_t;

    localparam int DEFAULT_H_PIX   = 640;
    localparam int DEFAULT_V_PIX   = 480;
    localparam int DEFAULT_SQ_SIZE = 10;

endpackage : draw_pkg

// File: rtl/raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter
// Two-dimensional x/y scan counter, x fastest. The registered position is the
// pixel being shown this cycle; x_next/y_next expose the position for the
// following cycle so the owner can register its outputs from them.
// Ports:
//   draw_clk, reset   : clock, asynchronous active-high reset
//   load              : next position is (0,0)
//   en                : advance one step (wraps to (0,0) after the last)
//   x_limit, y_limit  : last index in each dimension (inclusive)
//   x_next, y_next    : position that will be held after the next edge
//   last              : current position is (x_limit, y_limit)
// ---------------------------------------------------------------------------
module raster_counter
    import draw_pkg::*;
(
    input  logic       draw_clk,
    input  logic       reset,
    input  logic       load,
    input  logic       en,
    input  logic [9:0] x_limit,
    input  logic [8:0] y_limit,
    output logic [9:0] x_next,
    output logic [8:0] y_next,
    output logic       last
);

    xcoord_t x_q, x_d;
    ycoord_t y_q, y_d;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (x_q == x_limit) begin
                x_d = '0;
                y_d = (y_q == y_limit) ? '0 : y_q + 9'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    assign last   = (x_q == x_limit) && (y_q == y_limit);
    assign x_next = x_d;
    assign y_next = y_d;

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples its _d value from before the edge, regardless of order.
    always_ff @(posedge draw_clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule : raster_counter

// File: rtl/square_painter.sv
// ---------------------------------------------------------------------------
// square_painter
// Consumer of the snake/food coordinate stream. Per frame it clears the
// framebuffer to BG_COLOR, pulses `cleared` so the producer restarts its
// stream, then paints each accepted top-left coordinate as an
// SQ_SIZE x SQ_SIZE block of FG_COLOR through a single-pixel write port,
// until the producer reports stream_done.
// Ports:
//   draw_clk, reset      : clock, asynchronous active-high reset
//   frame_start          : start a frame (sampled only in IDLE)
//   in_valid/in_ready    : coordinate handshake; in_x/in_y = square top-left
//   stream_done          : producer has no more coordinates this frame
//   cleared              : one-cycle pulse after the clear completes
//   px_x/px_y/px_color   : pixel write address and colour
//   px_we                : pixel write enable (low for clipped pixels)
//   busy                 : high in every state except IDLE
//   frame_done           : one-cycle pulse at end of frame
// All outputs are registered: they are computed from next-state values.
// ---------------------------------------------------------------------------
module square_painter
    import draw_pkg::*;
#(
    parameter int   SQ_SIZE  = DEFAULT_SQ_SIZE,
    parameter int   H_PIX    = DEFAULT_H_PIX,
    parameter int   V_PIX    = DEFAULT_V_PIX,
    parameter logic FG_COLOR = 1'b1,
    parameter logic BG_COLOR = 1'b0
) (
    input  logic       draw_clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_x,
    input  logic [8:0] in_y,
    input  logic       stream_done,
    output logic       cleared,
    output logic [9:0] px_x,
    output logic [8:0] px_y,
    output logic       px_color,
    output logic       px_we,
    output logic       busy,
    output logic       frame_done
);

    localparam xcoord_t CLR_X_LAST = xcoord_t'(H_PIX - 1);
    localparam ycoord_t CLR_Y_LAST = ycoord_t'(V_PIX - 1);
    localparam xcoord_t SQ_X_LAST  = xcoord_t'(SQ_SIZE - 1);
    localparam ycoord_t SQ_Y_LAST  = ycoord_t'(SQ_SIZE - 1);

    painter_state_t state_q, state_d;

    xcoord_t cx_q, cx_d;
    ycoord_t cy_q, cy_d;
    logic    done_latch_q, done_latch_d;

    logic    in_ready_q, in_ready_d;
    logic    cleared_q, cleared_d;
    xcoord_t px_x_q, px_x_d;
    ycoord_t px_y_q, px_y_d;
    logic    px_color_q, px_color_d;
    logic    px_we_q, px_we_d;
    logic    busy_q, busy_d;
    logic    frame_done_q, frame_done_d;

    // One counter serves both the full-screen clear and the square scan;
    // it free-runs in CLEAR/PAINT and is parked at (0,0) everywhere else so
    // each scan starts from the origin on entry.
    logic    scan_load;
    logic    scan_last;
    xcoord_t scan_x_limit, scan_x_next;
    ycoord_t scan_y_limit, scan_y_next;

    assign scan_load    = !(state_q == CLEAR || state_q == PAINT);
    assign scan_x_limit = (state_q == CLEAR) ? CLR_X_LAST : SQ_X_LAST;
    assign scan_y_limit = (state_q == CLEAR) ? CLR_Y_LAST : SQ_Y_LAST;

    raster_counter u_scan (
        .draw_clk (draw_clk),
        .reset    (reset),
        .load     (scan_load),
        .en       (!scan_load),
        .x_limit  (scan_x_limit),
        .y_limit  (scan_y_limit),
        .x_next   (scan_x_next),
        .y_next   (scan_y_next),
        .last     (scan_last)
    );

    // Square pixel sums are widened by one bit so a coordinate near the edge
    // (or a wrapped negative one) is seen as off-screen rather than wrapping.
    logic [10:0] sum_x;
    logic [9:0]  sum_y;

    assign sum_x = {1'b0, cx_d} + {1'b0, scan_x_next};
    assign sum_y = {1'b0, cy_d} + {1'b0, scan_y_next};

    // Next-state and capture logic.
    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        done_latch_d = done_latch_q;

        unique case (state_q)
            IDLE:  if (frame_start) state_d = CLEAR;
            CLEAR: if (scan_last)   state_d = SYNC;
            SYNC:  state_d = WAIT;
            WAIT: begin
                // A coordinate beats a concurrent end-of-stream indication.
                if (in_valid && in_ready_q) begin
                    state_d = PAINT;
                    cx_d    = in_x;
                    cy_d    = in_y;
                end else if (done_latch_q) begin
                    state_d = DONE;
                end
            end
            PAINT: if (scan_last)   state_d = WAIT;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Stale stream_done from a previous frame must not end this one.
        if (state_q == IDLE && state_d == CLEAR) begin
            done_latch_d = 1'b0;
        end else if ((state_q == WAIT || state_q == PAINT) && stream_done) begin
            done_latch_d = 1'b1;
        end
    end

    // Output values for the cycle that follows the next edge.
    always_comb begin
        in_ready_d   = (state_d == WAIT);
        cleared_d    = (state_d == SYNC);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
        px_x_d       = '0;
        px_y_d       = '0;
        px_color_d   = 1'b0;
        px_we_d      = 1'b0;

        if (state_d == CLEAR) begin
            px_x_d     = scan_x_next;
            px_y_d     = scan_y_next;
            px_color_d = BG_COLOR;
            px_we_d    = 1'b1;
        end else if (state_d == PAINT) begin
            // Clipped pixels still take their cycle so square latency is fixed.
            px_x_d     = sum_x[9:0];
            px_y_d     = sum_y[8:0];
            px_color_d = FG_COLOR;
            px_we_d    = (sum_x < 11'(H_PIX)) && (sum_y < 10'(V_PIX));
        end
    end

    always_ff @(posedge draw_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cx_q         <= '0;
            cy_q         <= '0;
            done_latch_q <= 1'b0;
            in_ready_q   <= 1'b0;
            cleared_q    <= 1'b0;
            px_x_q       <= '0;
            px_y_q       <= '0;
            px_color_q   <= 1'b0;
            px_we_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            done_latch_q <= done_latch_d;
            in_ready_q   <= in_ready_d;
            cleared_q    <= cleared_d;
            px_x_q       <= px_x_d;
            px_y_q       <= px_y_d;
            px_color_q   <= px_color_d;
            px_we_q      <= px_we_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign cleared    = cleared_q;
    assign px_x       = px_x_q;
    assign px_y       = px_y_q;
    assign px_color   = px_color_q;
    assign px_we      = px_we_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule : square_painter

// File: tb/tb_square_painter.sv
// ---------------------------------------------------------------------------
// tb_square_painter
// Directed bench for square_painter with a 20x10 screen and 2x2 squares.
// Inputs change and outputs are sampled on the falling edge of draw_clk.
// ---------------------------------------------------------------------------
module tb_square_painter;

    localparam int H  = 20;
    localparam int V  = 10;
    localparam int SQ = 2;

    logic       draw_clk    = 1'b0;
    logic       reset       = 1'b1;
    logic       frame_start = 1'b0;
    logic       in_valid    = 1'b0;
    logic [9:0] in_x        = '0;
    logic [8:0] in_y        = '0;
    logic       stream_done = 1'b0;

    logic       in_ready;
    logic       cleared;
    logic [9:0] px_x;
    logic [8:0] px_y;
    logic       px_color;
    logic       px_we;
    logic       busy;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;

    square_painter #(
        .SQ_SIZE  (SQ),
        .H_PIX    (H),
        .V_PIX    (V),
        .FG_COLOR (1'b1),
        .BG_COLOR (1'b0)
    ) dut (
        .draw_clk    (draw_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .stream_done (stream_done),
        .cleared     (cleared),
        .px_x        (px_x),
        .px_y        (px_y),
        .px_color    (px_color),
        .px_we       (px_we),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 draw_clk = ~draw_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge draw_clk);
    endtask

    // Bounded wait for WAIT state; expiry counts as a failed comparison.
    task automatic wait_for_ready(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            $display("FAIL %s: in_ready=%b after %0d cycles, required 1", tag, in_ready, n);
            n_err++;
        end
    endtask

    task automatic test_reset();
        tick();
        n_cmp++;
        if ({in_ready, cleared, px_x, px_y, px_color, px_we, busy, frame_done} !== '0) begin
            $display("FAIL reset_outputs: got rdy=%b clr=%b x=%0d y=%0d c=%b we=%b busy=%b fd=%b, required all 0",
                     in_ready, cleared, px_x, px_y, px_color, px_we, busy, frame_done);
            n_err++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({busy, px_we, in_ready} !== 3'b000) begin
                $display("FAIL idle_after_reset[%0d]: busy=%b we=%b rdy=%b, required 000", i, busy, px_we, in_ready);
                n_err++;
            end
        end
    endtask

    task automatic test_clear();
        logic [9:0] ex;
        logic [8:0] ey;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < H * V; i++) begin
            ex = 10'(i % H);
            ey = 9'(i / H);
            n_cmp++;
            if ({px_we, px_color, busy, px_x, px_y} !== {1'b1, 1'b0, 1'b1, ex, ey}) begin
                $display("FAIL clear_px[%0d]: we=%b c=%b busy=%b (%0d,%0d), required we=1 c=0 busy=1 (%0d,%0d)",
                         i, px_we, px_color, busy, px_x, px_y, ex, ey);
                n_err++;
            end
            tick();
        end
        n_cmp++;
        if ({cleared, px_we, in_ready} !== 3'b100) begin
            $display("FAIL sync_cycle: cleared=%b we=%b rdy=%b, required 100", cleared, px_we, in_ready);
            n_err++;
        end
        tick();
        n_cmp++;
        if ({cleared, px_we, in_ready} !== 3'b001) begin
            $display("FAIL enter_wait: cleared=%b we=%b rdy=%b, required 001", cleared, px_we, in_ready);
            n_err++;
        end
    endtask

    task automatic test_paint();
        logic [9:0] ex;
        logic [8:0] ey;
        in_valid = 1'b1;
        in_x = 10'd4;
        in_y = 9'd2;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < SQ * SQ; k++) begin
            ex = 10'(4 + k % SQ);
            ey = 9'(2 + k / SQ);
            n_cmp++;
            if ({px_x, px_y, px_we, px_color, in_ready} !== {ex, ey, 1'b1, 1'b1, 1'b0}) begin
                $display("FAIL paint_px[%0d]: (%0d,%0d) we=%b c=%b rdy=%b, required (%0d,%0d) we=1 c=1 rdy=0",
                         k, px_x, px_y, px_we, px_color, in_ready, ex, ey);
                n_err++;
            end
            tick();
        end
        n_cmp++;
        if ({in_ready, px_we} !== 2'b10) begin
            $display("FAIL paint_return: rdy=%b we=%b, required rdy=1 we=0", in_ready, px_we);
            n_err++;
        end
    endtask

    task automatic test_clip();
        logic [9:0] ex;
        logic [8:0] ey;
        logic       ewe;
        // Bottom-right corner: only the anchor pixel lands on screen.
        in_valid = 1'b1;
        in_x = 10'd19;
        in_y = 9'd9;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < SQ * SQ; k++) begin
            ex  = 10'(19 + k % SQ);
            ey  = 9'(9 + k / SQ);
            ewe = (k == 0);
            n_cmp++;
            if ({px_x, px_y, px_we, px_color} !== {ex, ey, ewe, 1'b1}) begin
                $display("FAIL clip_corner[%0d]: (%0d,%0d) we=%b c=%b, required (%0d,%0d) we=%b c=1",
                         k, px_x, px_y, px_we, px_color, ex, ey, ewe);
                n_err++;
            end
            tick();
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            $display("FAIL clip_corner_return: rdy=%b, required 1", in_ready);
            n_err++;
        end
        // Wrapped negative x: whole square off screen, same latency.
        in_valid = 1'b1;
        in_x = 10'd1016;
        in_y = 9'd2;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < SQ * SQ; k++) begin
            ex = 10'(1016 + k % SQ);
            ey = 9'(2 + k / SQ);
            n_cmp++;
            if ({px_x, px_y, px_we, in_ready} !== {ex, ey, 1'b0, 1'b0}) begin
                $display("FAIL clip_neg[%0d]: (%0d,%0d) we=%b rdy=%b, required (%0d,%0d) we=0 rdy=0",
                         k, px_x, px_y, px_we, in_ready, ex, ey);
                n_err++;
            end
            tick();
        end
        n_cmp++;
        if ({in_ready, px_we} !== 2'b10) begin
            $display("FAIL clip_neg_return: rdy=%b we=%b, required rdy=1 we=0", in_ready, px_we);
            n_err++;
        end
    endtask

    task automatic test_done();
        // frame_start stays high for the rest of the frame and must be ignored.
        frame_start = 1'b1;
        in_valid = 1'b1;
        in_x = 10'd0;
        in_y = 9'd0;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({px_x, px_y, px_we} !== {10'd0, 9'd0, 1'b1}) begin
            $display("FAIL done_first_px: (%0d,%0d) we=%b, required (0,0) we=1", px_x, px_y, px_we);
            n_err++;
        end
        stream_done = 1'b1;
        tick();
        stream_done = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if ({in_ready, frame_done, busy, px_we} !== 4'b1010) begin
            $display("FAIL done_wait: rdy=%b fd=%b busy=%b we=%b, required 1010", in_ready, frame_done, busy, px_we);
            n_err++;
        end
        tick();
        n_cmp++;
        if ({in_ready, frame_done, busy, px_we} !== 4'b0110) begin
            $display("FAIL done_pulse: rdy=%b fd=%b busy=%b we=%b, required 0110", in_ready, frame_done, busy, px_we);
            n_err++;
        end
        tick();
        n_cmp++;
        if ({frame_done, busy, px_we} !== 3'b000) begin
            $display("FAIL done_idle: fd=%b busy=%b we=%b, required 000", frame_done, busy, px_we);
            n_err++;
        end
        tick();
        frame_start = 1'b0;
        n_cmp++;
        if ({busy, px_we, px_x, px_y} !== {1'b1, 1'b1, 10'd0, 9'd0}) begin
            $display("FAIL done_restart: busy=%b we=%b (%0d,%0d), required busy=1 we=1 (0,0)",
                     busy, px_we, px_x, px_y);
            n_err++;
        end
        wait_for_ready("done_next_frame");
    endtask

    task automatic test_reset_mid_paint();
        in_valid = 1'b1;
        in_x = 10'd7;
        in_y = 9'd3;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if ({px_x, px_y, px_we, busy} !== {10'd8, 9'd3, 1'b1, 1'b1}) begin
            $display("FAIL mid_paint_dx1: (%0d,%0d) we=%b busy=%b, required (8,3) we=1 busy=1",
                     px_x, px_y, px_we, busy);
            n_err++;
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({px_we, busy, in_ready, px_x, px_y} !== '0) begin
            $display("FAIL async_reset: we=%b busy=%b rdy=%b (%0d,%0d), required all 0",
                     px_we, busy, in_ready, px_x, px_y);
            n_err++;
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({busy, px_we} !== 2'b00) begin
            $display("FAIL post_reset_idle: busy=%b we=%b, required 00", busy, px_we);
            n_err++;
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_cmp++;
        if ({busy, px_we, px_color, px_x, px_y} !== {1'b1, 1'b1, 1'b0, 10'd0, 9'd0}) begin
            $display("FAIL restart_first: busy=%b we=%b c=%b (%0d,%0d), required 1,1,0 (0,0)",
                     busy, px_we, px_color, px_x, px_y);
            n_err++;
        end
        tick();
        n_cmp++;
        if ({px_we, px_x, px_y} !== {1'b1, 10'd1, 9'd0}) begin
            $display("FAIL restart_second: we=%b (%0d,%0d), required we=1 (1,0)", px_we, px_x, px_y);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_paint();
        test_clip();
        test_done();
        test_reset_mid_paint();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_square_painter
